// File: rtl/noc_in_pkg.sv
// Shared register offsets and bit positions for the NoC input port.
package noc_in_pkg;

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_STATUS   = 2'd1;
   localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
   localparam logic [1:0] ADDR_PEEK     = 2'd3;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_UDF     = 3;
   localparam int ST_LVL_LSB = 8;

   localparam int IM_NOT_EMPTY = 0;
   localparam int IM_OVF       = 1;
   localparam int IM_W         = 2;

endpackage

// File: rtl/nios_noc_input_port_if.sv
// Avalon-MM slave bus plus NoC push strobe for the NoC input port.
// Avalon: one transfer per cycle of chipselect with read_n or write_n low,
// zero wait states; the NoC push (in_valid) is a one-cycle strobe with no backpressure.
interface nios_noc_input_port_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [31:0] in_data;
   logic        in_valid;
   logic        irq;

   modport slave (
      input  address, chipselect, read_n, write_n, writedata, in_data, in_valid,
      output readdata, irq
   );

   modport master (
      output address, chipselect, read_n, write_n, writedata, in_data, in_valid,
      input  readdata, irq
   );
endinterface

// File: rtl/noc_in_fifo.sv
// Synchronous FIFO; a pop frees a slot so a push while full is still accepted.
module noc_in_fifo #(
   parameter int DEPTH = 8,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_W'(DEPTH));
   assign level = level_q;
   assign rdata = mem_q[rd_ptr_q];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointers are PTR_W wide, so wrap modulo DEPTH falls out of the add.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end
endmodule

// File: rtl/nios_noc_input_port.sv
// NoC receive port: buffers pushed words for the Nios II behind DATA/STATUS/IRQ_MASK/PEEK.
// Define NOC_IN_IRQ_EN to build the IRQ_MASK register and irq output; otherwise irq is 0.
module nios_noc_input_port
   import noc_in_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   nios_noc_input_port_if.slave         bus
);
   logic             rd_strobe, wr_strobe, pop, wr_status;
   logic [31:0]      head, head_or_zero, status, mask_rd;
   logic             full, empty;
   logic [LVL_W-1:0] level;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   assign rd_strobe = bus.chipselect && !bus.read_n;
   assign wr_strobe = bus.chipselect && !bus.write_n;
   assign pop       = rd_strobe && (bus.address == ADDR_DATA);
   assign wr_status = wr_strobe && (bus.address == ADDR_STATUS);

   noc_in_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
      .clk   (clk),
      .rst_n (reset_n),
      .push  (bus.in_valid),
      .pop   (pop),
      .wdata (bus.in_data),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // A same-cycle pop makes room, so only an unmatched push while full overflows; set beats clear.
   always_comb begin
      ovf_d = (ovf_q && !(wr_status && bus.writedata[ST_OVF]))
            || (bus.in_valid && full && !pop);
      udf_d = (udf_q && !(wr_status && bus.writedata[ST_UDF]))
            || (pop && empty);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

`ifdef NOC_IN_IRQ_EN
   logic [IM_W-1:0] mask_q, mask_d;

   always_comb begin
      mask_d = mask_q;
      if (wr_strobe && (bus.address == ADDR_IRQ_MASK)) mask_d = bus.writedata[IM_W-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mask_q <= '0;
      else          mask_q <= mask_d;
   end

   assign mask_rd = {{(32-IM_W){1'b0}}, mask_q};
   assign bus.irq = (mask_q[IM_NOT_EMPTY] && !empty) || (mask_q[IM_OVF] && ovf_q);
`else
   assign mask_rd = '0;
   assign bus.irq = 1'b0;
`endif

   assign head_or_zero = empty ? '0 : head;

   always_comb begin
      status                        = '0;
      status[ST_EMPTY]              = empty;
      status[ST_FULL]               = full;
      status[ST_OVF]                = ovf_q;
      status[ST_UDF]                = udf_q;
      status[ST_LVL_LSB +: LVL_W]   = level;
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         ADDR_DATA:     bus.readdata = head_or_zero;
         ADDR_STATUS:   bus.readdata = status;
         ADDR_IRQ_MASK: bus.readdata = mask_rd;
         ADDR_PEEK:     bus.readdata = head_or_zero;
         default:       bus.readdata = '0;
      endcase
   end
endmodule

// File: tb/tb_nios_noc_input_port.sv
// Scoreboarded bench for nios_noc_input_port: directed register tests plus random traffic.
module tb_nios_noc_input_port;
   import noc_in_pkg::*;

   localparam int DEPTH = 8;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nios_noc_input_port_if bus ();

   nios_noc_input_port #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   // scoreboard / model state
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];
   bit          m_ovf;
   bit          m_udf;
   logic [1:0]  m_mask;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s                       = '0;
      s[ST_EMPTY]             = (exp_q.size() == 0);
      s[ST_FULL]              = (exp_q.size() == DEPTH);
      s[ST_OVF]               = m_ovf;
      s[ST_UDF]               = m_udf;
      s[ST_LVL_LSB +: LVL_W]  = LVL_W'(exp_q.size());
      return s;
   endfunction

   function automatic logic exp_irq();
`ifdef NOC_IN_IRQ_EN
      return (m_mask[0] && exp_q.size() != 0) || (m_mask[1] && m_ovf);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] exp_head();
      return (exp_q.size() != 0) ? exp_q[0] : 32'h0;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_mask = 2'b00;
   endtask

   // driver: one bus cycle, checked at negedge+1, model advanced for the coming posedge
   task automatic bus_cycle(input bit do_push, input logic [31:0] word, input bit do_rd,
                            input bit do_wr, input logic [1:0] addr,
                            input logic [31:0] wdata, input string tag);
      @(negedge clk);
      bus.in_valid   = do_push;
      bus.in_data    = word;
      bus.chipselect = do_rd || do_wr;
      bus.read_n     = !do_rd;
      bus.write_n    = !do_wr;
      bus.address    = addr;
      bus.writedata  = wdata;
      #1;
      chk({tag, "/irq"}, {31'b0, bus.irq}, {31'b0, exp_irq()});
      if (do_rd) begin
         case (addr)
            ADDR_DATA:     chk({tag, "/data"},   bus.readdata, exp_head());
            ADDR_STATUS:   chk({tag, "/status"}, bus.readdata, exp_status());
            ADDR_IRQ_MASK: chk({tag, "/mask"},   bus.readdata, {30'b0, m_mask});
            default:       chk({tag, "/peek"},   bus.readdata, exp_head());
         endcase
      end
      if (do_rd && addr == ADDR_DATA) begin
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         else                   m_udf = 1'b1;
      end
      if (do_wr && addr == ADDR_STATUS) begin
         if (wdata[ST_OVF]) m_ovf = 1'b0;
         if (wdata[ST_UDF]) m_udf = 1'b0;
      end
`ifdef NOC_IN_IRQ_EN
      if (do_wr && addr == ADDR_IRQ_MASK) m_mask = wdata[1:0];
`endif
      if (do_push) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(word);
         else                      m_ovf = 1'b1;
      end
      @(posedge clk);
   endtask

   task automatic push(input logic [31:0] w);
      bus_cycle(1'b1, w, 1'b0, 1'b0, ADDR_DATA, 32'h0, "push");
   endtask

   task automatic rd(input logic [1:0] a, input string tag);
      bus_cycle(1'b0, 32'h0, 1'b1, 1'b0, a, 32'h0, tag);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input string tag);
      bus_cycle(1'b0, 32'h0, 1'b0, 1'b1, a, d, tag);
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.chipselect = 1'b0;
      bus.read_n     = 1'b1;
      bus.write_n    = 1'b1;
      bus.address    = '0;
      bus.writedata  = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // reset state
      rd(ADDR_STATUS, "rst");
      chk("rst_status_raw", bus.readdata, 32'h0000_0001);

      // two pushes, two pops
      push(32'hA5A5_0001);
      push(32'hA5A5_0002);
      rd(ADDR_DATA, "pop1");
      rd(ADDR_DATA, "pop2");
      rd(ADDR_STATUS, "after2");

      // overflow with nine pushes
      for (int i = 1; i <= 9; i++) push(32'h1000_0000 + i);
      rd(ADDR_STATUS, "ovf9");
      chk("ovf9_raw", bus.readdata, 32'h0000_0806);
      for (int i = 0; i < 8; i++) rd(ADDR_DATA, "drain8");
      wr(ADDR_STATUS, 32'h4, "clr_ovf");
      rd(ADDR_STATUS, "after_clr");

      // full + simultaneous push/pop
      for (int i = 0; i < 8; i++) push(32'h2000_0000 + i);
      bus_cycle(1'b1, 32'h2000_00FF, 1'b1, 1'b0, ADDR_DATA, 32'h0, "full_pp");
      rd(ADDR_STATUS, "full_pp_st");
      for (int i = 0; i < 8; i++) rd(ADDR_DATA, "drain_pp");

      // underflow, then empty push/pop together, then peek
      rd(ADDR_DATA, "udf");
      rd(ADDR_STATUS, "udf_st");
      bus_cycle(1'b1, 32'h3000_0001, 1'b1, 1'b0, ADDR_DATA, 32'h0, "empty_pp");
      rd(ADDR_STATUS, "empty_pp_st");
      wr(ADDR_STATUS, 32'hC, "clr_both");
      rd(ADDR_PEEK, "peek1");
      rd(ADDR_PEEK, "peek2");
      rd(ADDR_STATUS, "peek_st");
      rd(ADDR_DATA, "peek_pop");

      // interrupt mask
      wr(ADDR_IRQ_MASK, 32'h1, "mask1");
      rd(ADDR_IRQ_MASK, "mask1_rd");
      rd(ADDR_STATUS, "irq_idle");
      push(32'h4000_0001);
      push(32'h4000_0002);
      rd(ADDR_DATA, "irq_pop1");
      rd(ADDR_DATA, "irq_pop2");
      rd(ADDR_STATUS, "irq_fall");
      wr(ADDR_IRQ_MASK, 32'h2, "mask2");
      for (int i = 0; i < 9; i++) push(32'h5000_0000 + i);
      rd(ADDR_STATUS, "irq_ovf");
      wr(ADDR_STATUS, 32'h4, "irq_ovf_clr");
      rd(ADDR_STATUS, "irq_ovf_gone");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         int          op;
         bit          p;
         logic [1:0]  a;
         logic [31:0] d;
         op = $urandom_range(0, 3);
         p  = ($urandom_range(0, 1) == 1);
         a  = 2'($urandom_range(0, 3));
         d  = $urandom;
         case (op)
            1, 2:    bus_cycle(p, d, 1'b1, 1'b0, a, 32'h0, "rnd_rd");
            3:       bus_cycle(p, d, 1'b0, 1'b1, a, {28'h0, d[3:0]}, "rnd_wr");
            default: bus_cycle(p, d, 1'b0, 1'b0, a, 32'h0, "rnd_idle");
         endcase
      end

      // reset mid-operation discards buffered words
      wr(ADDR_IRQ_MASK, 32'h3, "pre_rst_mask");
      for (int i = 0; i < 3; i++) push(32'h6000_0000 + i);
      #2;
      rst_n = 1'b0;
      model_reset();
      rd(ADDR_STATUS, "mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      rd(ADDR_STATUS, "post_rst");
      rd(ADDR_IRQ_MASK, "post_rst_mask");
      rd(ADDR_DATA, "post_rst_pop");

      bus_cycle(1'b0, 32'h0, 1'b0, 1'b0, ADDR_DATA, 32'h0, "idle");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/nios_noc_input_port.md
# nios_noc_input_port

Avalon-MM slave that receives words pushed from the NoC into the Nios II system and buffers them for the CPU. It receives pushes from the NoC, stores them in a small FIFO, and exposes data, status and interrupt-mask registers on a 2-bit word-addressed slave. It sits beside the NoC output PIO and forms the receive path of the same processor-to-NoC link.

## Interface
- DEPTH, 8, FIFO depth in words; power of two, 2..16
- LVL_W, $clog2(DEPTH)+1, width of the level count
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register word select
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address (zero wait states)
- in_data  in  32  NoC word
- in_valid  in  1  single-cycle push strobe; NoC applies no backpressure
- irq  out  1  level interrupt to the Nios II

## Operation
- Register map:
  - 0 DATA (read pops the head).
  - 1 STATUS:
    - bit0 empty
    - bit1 full
    - bit2 overflow (sticky)
    - bit3 underflow (sticky)
    - bits[8+LVL_W-1:8] level
    - writing 1 to bit2 or bit3 clears that bit.
  - 2 IRQ_MASK: bit0 not-empty enable, bit1 overflow enable; read/write.
  - 3 PEEK: returns the head without popping. Returns 0 when empty.
- Push:
  - in_valid while not full writes in_data at the tail and increments level.
  - in_valid while full drops the word and sets overflow.
- Pop:
  - chipselect && !read_n && address==0 drives the head on readdata and advances the head at that clock edge.
  - Pop when empty returns 0, leaves pointers unchanged and sets underflow.
- Reads of unused bits return 0. Writes to DATA and PEEK are ignored.
- irq = (mask[0] & !empty) | (mask[1] & overflow).
- Pointers wrap modulo DEPTH. Level ranges 0..DEPTH.

## Timing
- Reset values: FIFO empty, level 0, overflow 0, underflow 0, IRQ_MASK 0, irq 0. readdata is 0 except on a STATUS read, which returns 1 (empty).
- readdata is valid in the same cycle as the read strobe. All state updates on the rising edge.
- Push-to-visible latency: a word pushed at edge N is readable at DATA or PEEK in cycle N+1. STATUS and irq change in the same cycle.
- Simultaneous push and pop:
  - When not empty, level is unchanged and both are accepted.
  - When full, the pop frees a slot, the push is accepted and no overflow is set.
  - When empty, the pop is an underflow (returns 0) and the push is accepted.
- Overflow set and write-1-clear in the same cycle: set wins.
- A read strobe held over k cycles pops k words. Avalon read_n is single-cycle per transfer with zero wait states.
- Reset asserted mid-operation clears all state immediately. Buffered words are discarded.

## Configuration
- NOC_IN_IRQ_EN defined:
  - IRQ_MASK register and irq logic are present as above.
- NOC_IN_IRQ_EN undefined:
  - irq is tied to 0.
  - IRQ_MASK reads 0 and ignores writes.
  - All other behaviour is identical.

## Structure
- Package noc_in_pkg holds:
  - register offsets (ADDR_DATA=0, ADDR_STATUS=1, ADDR_IRQ_MASK=2, ADDR_PEEK=3)
  - STATUS bit positions (ST_EMPTY, ST_FULL, ST_OVF, ST_UDF, ST_LVL_LSB=8)
  - IRQ_MASK bit positions.
- Sub-module noc_in_fifo implements the synchronous FIFO with parameter DEPTH. Its ports are push, pop, wdata, rdata (head), full, empty and level; it also owns the simultaneous push/pop-when-full rule.
- The top level contains the register decode, the sticky flags, the mask and irq.

## Test plan
- Reset, then read STATUS: readdata=0x00000001 and irq=0.
- Push 0xA5A5_0001, 0xA5A5_0002, then read DATA twice: returns 0xA5A5_0001 then 0xA5A5_0002. After that, STATUS=0x1.
- Push 9 words with DEPTH=8: STATUS bit1=1, bit2=1, level=8. Eight DATA reads return words 1..8. Write 0x4 to STATUS and overflow clears.
- With the FIFO full, push and pop in the same cycle: the popped word is the oldest, level stays 8 and overflow stays 0.
- Read DATA when empty: readdata=0 and STATUS bit3=1. A PEEK read on a one-word FIFO returns the word twice with level unchanged.
- Write IRQ_MASK=0x1: irq rises one cycle after the first push and falls after the last pop. Under NOC_IN_IRQ_EN undefined, irq stays 0 throughout and IRQ_MASK reads 0.
